// File: rtl/btn_event.sv
// ---------------------------------------------------------------------------
// btn_event -- button debouncer and event generator.
//
// A raw (or stretched) button level is synchronized into the CLK domain and
// debounced. The debounced level is then turned into one-cycle event pulses:
// PRESS, RELEASE, LONG (button held LONG_CNT cycles) and, optionally, an
// auto-repeat REPEAT pulse every REPEAT_CNT cycles while the button stays
// long-held.
//
// Parameters
//   STABLE_CNT  cycles a new synchronized level must hold before acceptance
//   LONG_CNT    cycles from PRESS to LONG
//   REPEAT_CNT  cycles between REPEAT pulses
//
// Ports
//   CLK      in   single clock, all state on the rising edge
//   RESET    in   asynchronous, active-high reset
//   SIG_IN   in   button level, asynchronous to CLK, 1 = pressed
//   LEVEL    out  debounced button level
//   PRESS    out  one-cycle pulse on accepted 0->1
//   RELEASE  out  one-cycle pulse on accepted 1->0
//   LONG     out  one-cycle pulse once the button has been held LONG_CNT cycles
//   REPEAT   out  one-cycle auto-repeat pulse while long-held
//
// Configuration macro
//   BTN_EVENT_REPEAT_EN  defined: REPEAT pulses every REPEAT_CNT cycles in the
//                        long-held state. Undefined: REPEAT is held at 0 and
//                        REPEAT_CNT has no effect on the logic.
// ---------------------------------------------------------------------------
module btn_event #(
   parameter int STABLE_CNT = 4,
   parameter int LONG_CNT   = 1000,
   parameter int REPEAT_CNT = 250
) (
   input  logic CLK,
   input  logic RESET,
   input  logic SIG_IN,
   output logic LEVEL,
   output logic PRESS,
   output logic RELEASE,
   output logic LONG,
   output logic REPEAT
);

   // Reject out-of-range parameters at elaboration rather than building a
   // debouncer whose counters can never reach their terminal values.
   if (STABLE_CNT < 1 || STABLE_CNT > 65535) begin : g_bad_stable
      $error("btn_event: STABLE_CNT out of range 1..65535");
   end
   if (LONG_CNT < 2 || LONG_CNT > 65535) begin : g_bad_long
      $error("btn_event: LONG_CNT out of range 2..65535");
   end
   if (REPEAT_CNT < 2 || REPEAT_CNT > 65535) begin : g_bad_repeat
      $error("btn_event: REPEAT_CNT out of range 2..65535");
   end

   localparam logic [15:0] STABLE_LAST = 16'(STABLE_CNT - 1);
   localparam logic [15:0] LONG_LAST   = 16'(LONG_CNT - 1);
`ifdef BTN_EVENT_REPEAT_EN
   localparam logic [15:0] REPEAT_LAST = 16'(REPEAT_CNT - 1);
`endif

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DOWN     = 2'd1,
      LONGHELD = 2'd2
   } state_t;

   logic        s1;
   logic        s2;
   logic [15:0] stable_cnt;
   logic        differs;
   logic        accept;
   logic        press_acc;
   logic        release_acc;

   state_t      state;
   state_t      state_next;
   logic [15:0] hold_cnt;
   logic [15:0] hold_next;
   logic        press_next;
   logic        release_next;
   logic        long_next;
   logic        repeat_next;

   // Two-flop synchronizer; s1 is the only flop that ever sees SIG_IN.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= SIG_IN;
         s2 <= s1;
      end
   end

   // The synchronized level must disagree with LEVEL for STABLE_CNT
   // consecutive cycles before it is accepted. Any cycle where s2 agrees
   // with LEVEL again throws away the partial qualification.
   assign differs     = (s2 != LEVEL);
   assign accept      = differs && (stable_cnt == STABLE_LAST);
   assign press_acc   = accept && s2;
   assign release_acc = accept && !s2;

   // Debounced level and its stability counter.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         stable_cnt <= 16'd0;
         LEVEL      <= 1'b0;
      end else if (!differs) begin
         stable_cnt <= 16'd0;
      end else if (accept) begin
         stable_cnt <= 16'd0;
         LEVEL      <= s2;
      end else begin
         stable_cnt <= stable_cnt + 16'd1;
      end
   end

   // FSM state, hold counter and registered event pulses. The pulses are
   // registered on the same edge that updates LEVEL, so PRESS/RELEASE are
   // high exactly in the first cycle LEVEL shows its new value.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state    <= IDLE;
         hold_cnt <= 16'd0;
         PRESS    <= 1'b0;
         RELEASE  <= 1'b0;
         LONG     <= 1'b0;
         REPEAT   <= 1'b0;
      end else begin
         state    <= state_next;
         hold_cnt <= hold_next;
         PRESS    <= press_next;
         RELEASE  <= release_next;
         LONG     <= long_next;
         REPEAT   <= repeat_next;
      end
   end

   // Next-state and next-pulse logic. An accepted release is checked before
   // the hold counter terminal count, so a release landing in the same cycle
   // as a due LONG or REPEAT suppresses that pulse. Only one branch can fire
   // per cycle, which keeps the four pulses mutually exclusive.
   always_comb begin
      state_next   = state;
      hold_next    = hold_cnt;
      press_next   = 1'b0;
      release_next = 1'b0;
      long_next    = 1'b0;
      repeat_next  = 1'b0;
      case (state)
         IDLE: begin
            hold_next = 16'd0;
            if (press_acc) begin
               state_next = DOWN;
               press_next = 1'b1;
            end
         end
         DOWN: begin
            if (release_acc) begin
               state_next   = IDLE;
               release_next = 1'b1;
               hold_next    = 16'd0;
            end else if (hold_cnt == LONG_LAST) begin
               state_next = LONGHELD;
               long_next  = 1'b1;
               hold_next  = 16'd0;
            end else begin
               hold_next = hold_cnt + 16'd1;
            end
         end
         LONGHELD: begin
            if (release_acc) begin
               state_next   = IDLE;
               release_next = 1'b1;
               hold_next    = 16'd0;
            end else begin
`ifdef BTN_EVENT_REPEAT_EN
               if (hold_cnt == REPEAT_LAST) begin
                  repeat_next = 1'b1;
                  hold_next   = 16'd0;
               end else begin
                  hold_next = hold_cnt + 16'd1;
               end
`else
               hold_next = 16'd0;
`endif
            end
         end
         default: begin
            state_next = IDLE;
            hold_next  = 16'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_btn_event.sv
// ---------------------------------------------------------------------------
// tb_btn_event -- self-checking bench for btn_event with STABLE_CNT=4,
// LONG_CNT=20, REPEAT_CNT=5.
//
// The reference model works from the input history: LEVEL flips at an edge
// when the last STABLE_CNT synchronizer outputs (SIG_IN two edges earlier)
// all disagreed with the current level since the previous flip. Event
// pulses are derived from the press timestamp P: LONG at P+LONG_CNT,
// REPEAT at P+LONG_CNT+k*REPEAT_CNT, with a release flip taking priority.
// ---------------------------------------------------------------------------
module tb_btn_event;

   localparam int S = 4;
   localparam int L = 20;
   localparam int R = 5;

   logic CLK = 1'b0;
   logic RESET;
   logic SIG_IN;
   logic LEVEL;
   logic PRESS;
   logic RELEASE;
   logic LONG;
   logic REPEAT;

   int checks = 0;
   int passed = 0;

   int   cyc = 0;
   bit   hist [0:8191];
   int   first_edge = 1;
   int   last_flip = 0;
   bit   m_level = 1'b0;
   int   press_edge = -100000;
   logic [4:0] exp_out = 5'b0;

   always #5 CLK = ~CLK;

   btn_event #(
      .STABLE_CNT(S),
      .LONG_CNT(L),
      .REPEAT_CNT(R)
   ) dut (
      .CLK(CLK),
      .RESET(RESET),
      .SIG_IN(SIG_IN),
      .LEVEL(LEVEL),
      .PRESS(PRESS),
      .RELEASE(RELEASE),
      .LONG(LONG),
      .REPEAT(REPEAT)
   );

   function automatic bit hist_at(input int e);
      if (e < first_edge || e < 0) return 1'b0;
      return hist[e];
   endfunction

   // Advance the reference model by one rising edge.
   task automatic model_edge(input bit rst);
      bit flip;
      bit p;
      bit r;
      bit lg;
      bit rp;
      p = 0; r = 0; lg = 0; rp = 0;
      if (rst) begin
         first_edge = cyc + 1;
         last_flip  = cyc;
         m_level    = 1'b0;
         press_edge = -100000;
         exp_out    = 5'b0;
         return;
      end
      flip = 1'b1;
      for (int j = 0; j < S; j++) begin
         if ((cyc - j) <= last_flip || hist_at(cyc - j - 2) == m_level) flip = 1'b0;
      end
      if (flip) begin
         m_level   = ~m_level;
         last_flip = cyc;
         if (m_level) begin
            p = 1'b1;
            press_edge = cyc;
         end else begin
            r = 1'b1;
         end
      end else if (m_level) begin
         if (cyc == press_edge + L) lg = 1'b1;
`ifdef BTN_EVENT_REPEAT_EN
         if (cyc > press_edge + L && ((cyc - press_edge - L) % R) == 0) rp = 1'b1;
`endif
      end
      exp_out = {m_level, p, r, lg, rp};
   endtask

   // Drive one cycle of stimulus at the falling edge, advance the model at
   // the rising edge and return 1 time unit later for sampling.
   task automatic tick(input bit v, input bit rst);
      @(negedge CLK);
      SIG_IN = v;
      RESET  = rst;
      @(posedge CLK);
      cyc++;
      hist[cyc] = v;
      model_edge(rst);
      #1;
   endtask

   task automatic test_reset;
      RESET  = 1'b1;
      SIG_IN = 1'b0;
      #1;
      checks++;
      if ({LEVEL, PRESS, RELEASE, LONG, REPEAT} !== 5'b0)
         $display("[TB] FAIL reset_async got=%b exp=%b", {LEVEL, PRESS, RELEASE, LONG, REPEAT}, 5'b0);
      else passed++;
      for (int i = 0; i < 5; i++) begin
         tick(1'b0, i < 2);
         checks++;
         if ({LEVEL, PRESS, RELEASE, LONG, REPEAT} !== exp_out)
            $display("[TB] FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, {LEVEL, PRESS, RELEASE, LONG, REPEAT}, exp_out);
         else passed++;
      end
   endtask

   task automatic test_glitch;
      int events;
      events = 0;
      for (int i = 1; i <= 13; i++) begin
         tick(i <= 3, 1'b0);
         events += int'(PRESS) + int'(RELEASE) + int'(LEVEL);
         checks++;
         if ({LEVEL, PRESS, RELEASE, LONG, REPEAT} !== exp_out)
            $display("[TB] FAIL glitch cyc=%0d got=%b exp=%b", cyc, {LEVEL, PRESS, RELEASE, LONG, REPEAT}, exp_out);
         else passed++;
      end
      checks++;
      if (events !== 0) $display("[TB] FAIL glitch_events got=%0d exp=0", events);
      else passed++;
   endtask

   task automatic test_short_press;
      int press_at;
      int release_at;
      int nlong;
      press_at = -1; release_at = -1; nlong = 0;
      for (int i = 1; i <= 25; i++) begin
         tick(i <= 10, 1'b0);
         if (PRESS) press_at = i;
         if (RELEASE) release_at = i;
         nlong += int'(LONG);
         checks++;
         if ({LEVEL, PRESS, RELEASE, LONG, REPEAT} !== exp_out)
            $display("[TB] FAIL short_press cyc=%0d got=%b exp=%b", cyc, {LEVEL, PRESS, RELEASE, LONG, REPEAT}, exp_out);
         else passed++;
      end
      checks++;
      if (press_at !== 6) $display("[TB] FAIL short_press_at got=%0d exp=6", press_at);
      else passed++;
      checks++;
      if (release_at !== 16) $display("[TB] FAIL short_release_at got=%0d exp=16", release_at);
      else passed++;
      checks++;
      if (nlong !== 0) $display("[TB] FAIL short_no_long got=%0d exp=0", nlong);
      else passed++;
   endtask

   task automatic test_long_hold;
      int long_at;
      int first_rep;
      int nrep;
      int exp_nrep;
      long_at = -1; first_rep = -1; nrep = 0;
`ifdef BTN_EVENT_REPEAT_EN
      exp_nrep = 5;
`else
      exp_nrep = 0;
`endif
      for (int i = 1; i <= 65; i++) begin
         tick(i <= 50, 1'b0);
         if (LONG) long_at = i;
         if (REPEAT) begin
            nrep++;
            if (first_rep < 0) first_rep = i;
         end
         checks++;
         if ({LEVEL, PRESS, RELEASE, LONG, REPEAT} !== exp_out)
            $display("[TB] FAIL long_hold cyc=%0d got=%b exp=%b", cyc, {LEVEL, PRESS, RELEASE, LONG, REPEAT}, exp_out);
         else passed++;
      end
      checks++;
      if (long_at !== 26) $display("[TB] FAIL long_at got=%0d exp=26", long_at);
      else passed++;
      checks++;
      if (nrep !== exp_nrep) $display("[TB] FAIL repeat_count got=%0d exp=%0d", nrep, exp_nrep);
      else passed++;
`ifdef BTN_EVENT_REPEAT_EN
      checks++;
      if (first_rep !== 31) $display("[TB] FAIL first_repeat_at got=%0d exp=31", first_rep);
      else passed++;
`endif
   endtask

   task automatic test_release_at_long;
      int release_at;
      int nlong;
      release_at = -1; nlong = 0;
      for (int i = 1; i <= 32; i++) begin
         tick(i <= 20, 1'b0);
         if (RELEASE) release_at = i;
         nlong += int'(LONG);
         checks++;
         if ({LEVEL, PRESS, RELEASE, LONG, REPEAT} !== exp_out)
            $display("[TB] FAIL release_at_long cyc=%0d got=%b exp=%b", cyc, {LEVEL, PRESS, RELEASE, LONG, REPEAT}, exp_out);
         else passed++;
      end
      checks++;
      if (release_at !== 26) $display("[TB] FAIL release_wins_at got=%0d exp=26", release_at);
      else passed++;
      checks++;
      if (nlong !== 0) $display("[TB] FAIL release_wins_long got=%0d exp=0", nlong);
      else passed++;
   endtask

   task automatic test_bounce;
      bit pattern [1:5];
      int npress;
      int press_at;
      pattern = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      npress = 0; press_at = -1;
      for (int i = 1; i <= 32; i++) begin
         tick((i <= 5) ? pattern[i] : (i <= 20), 1'b0);
         if (PRESS) begin
            npress++;
            press_at = i;
         end
         checks++;
         if ({LEVEL, PRESS, RELEASE, LONG, REPEAT} !== exp_out)
            $display("[TB] FAIL bounce cyc=%0d got=%b exp=%b", cyc, {LEVEL, PRESS, RELEASE, LONG, REPEAT}, exp_out);
         else passed++;
      end
      checks++;
      if (npress !== 1) $display("[TB] FAIL bounce_press_count got=%0d exp=1", npress);
      else passed++;
      checks++;
      if (press_at !== 10) $display("[TB] FAIL bounce_press_at got=%0d exp=10", press_at);
      else passed++;
   endtask

   task automatic test_reset_mid_hold;
      int nrel;
      int press_at;
      nrel = 0; press_at = -1;
      for (int i = 1; i <= 30; i++) begin
         tick(1'b1, 1'b0);
         checks++;
         if ({LEVEL, PRESS, RELEASE, LONG, REPEAT} !== exp_out)
            $display("[TB] FAIL mid_hold_pre cyc=%0d got=%b exp=%b", cyc, {LEVEL, PRESS, RELEASE, LONG, REPEAT}, exp_out);
         else passed++;
      end
      #2;
      RESET = 1'b1;
      #1;
      checks++;
      if ({LEVEL, PRESS, RELEASE, LONG, REPEAT} !== 5'b0)
         $display("[TB] FAIL mid_reset_async got=%b exp=%b", {LEVEL, PRESS, RELEASE, LONG, REPEAT}, 5'b0);
      else passed++;
      for (int i = 1; i <= 2; i++) begin
         tick(1'b1, 1'b1);
         nrel += int'(RELEASE);
      end
      for (int i = 1; i <= 12; i++) begin
         tick(1'b1, 1'b0);
         nrel += int'(RELEASE);
         if (PRESS) press_at = i;
         checks++;
         if ({LEVEL, PRESS, RELEASE, LONG, REPEAT} !== exp_out)
            $display("[TB] FAIL mid_hold_requal cyc=%0d got=%b exp=%b", cyc, {LEVEL, PRESS, RELEASE, LONG, REPEAT}, exp_out);
         else passed++;
      end
      checks++;
      if (press_at !== 6) $display("[TB] FAIL requal_press_at got=%0d exp=6", press_at);
      else passed++;
      checks++;
      if (nrel !== 0) $display("[TB] FAIL reset_no_release got=%0d exp=0", nrel);
      else passed++;
      for (int i = 1; i <= 10; i++) tick(1'b0, 1'b0);
   endtask

   task automatic test_random;
      int hi_len;
      int lo_len;
      int bounce_len;
      for (int n = 0; n < 30; n++) begin
         bounce_len = $urandom_range(0, 4);
         hi_len     = $urandom_range(1, 45);
         lo_len     = $urandom_range(1, 12);
         for (int i = 0; i < bounce_len + hi_len + lo_len; i++) begin
            if (i < bounce_len) tick(1'($urandom_range(0, 1)), 1'b0);
            else tick(i < bounce_len + hi_len, 1'b0);
            checks++;
            if ({LEVEL, PRESS, RELEASE, LONG, REPEAT} !== exp_out)
               $display("[TB] FAIL random cyc=%0d got=%b exp=%b", cyc, {LEVEL, PRESS, RELEASE, LONG, REPEAT}, exp_out);
            else passed++;
            checks++;
            if ($countones({PRESS, RELEASE, LONG, REPEAT}) > 1)
               $display("[TB] FAIL pulse_onehot cyc=%0d got=%b exp=at_most_one", cyc, {PRESS, RELEASE, LONG, REPEAT});
            else passed++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_short_press();
      test_long_hold();
      test_release_at_long();
      test_bounce();
      test_reset_mid_hold();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/btn_event.md
BTN_EVENT -- requirements
Module: btn_event

Interface
REQ-001 SHALL provide parameter STABLE_CNT, default 4: consecutive cycles a new synchronized level must hold before acceptance (legal 1..65535).
REQ-002 SHALL provide parameter LONG_CNT, default 1000: cycles from PRESS to LONG (legal 2..65535).
REQ-003 SHALL provide parameter REPEAT_CNT, default 250: cycles between REPEAT pulses (legal 2..65535).
REQ-004 CLK  in  1  single clock; all state on rising edge.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 SIG_IN  in  1  raw or stretched button level, asynchronous to CLK, 1 = pressed.
REQ-007 LEVEL  out  1  debounced button level.
REQ-008 PRESS  out  1  one-cycle pulse on accepted 0->1.
REQ-009 RELEASE  out  1  one-cycle pulse on accepted 1->0.
REQ-010 LONG  out  1  one-cycle pulse after LONG_CNT cycles held.
REQ-011 REPEAT  out  1  one-cycle auto-repeat pulse while long-held.

Function
REQ-012 SIG_IN SHALL pass a 2-flop synchronizer (s1, s2); no other logic samples SIG_IN.
REQ-013 Stability counter (16 bit): cleared when s2 == LEVEL; incremented when s2 != LEVEL; when s2 != LEVEL and counter == STABLE_CNT-1, LEVEL <= s2 and counter cleared.
REQ-014 Latency: SIG_IN stable from before edge 1 SHALL flip LEVEL at edge 2+STABLE_CNT; any s2 return to LEVEL earlier restarts qualification.
REQ-015 PRESS/RELEASE SHALL be registered, high exactly the first cycle LEVEL shows the new value.
REQ-016 FSM states IDLE, DOWN, LONGHELD; IDLE->DOWN on accepted press (hold counter cleared).
REQ-017 DOWN: hold counter (16 bit) increments each cycle; at LONG_CNT-1 -> LONG pulse, go LONGHELD, counter cleared; LONG high at cycle P+LONG_CNT, P = PRESS cycle.
REQ-018 LONGHELD: hold counter increments, wraps to 0 at REPEAT_CNT-1 issuing REPEAT (see REQ-024).
REQ-019 Accepted release in DOWN or LONGHELD -> IDLE, RELEASE pulse, counter cleared.
REQ-020 Release and LONG/REPEAT due in same cycle: release wins; LONG/REPEAT SHALL NOT assert.
REQ-021 At most one of PRESS, RELEASE, LONG, REPEAT high in any cycle.

Reset
REQ-022 RESET high SHALL immediately force s1, s2, LEVEL, all counters and all outputs to 0 and FSM to IDLE, independent of CLK.
REQ-023 Reset mid-hold SHALL NOT produce RELEASE; after deassertion a still-high SIG_IN requalifies as a new press (PRESS at edge 2+STABLE_CNT).

Configuration
REQ-024 Macro BTN_EVENT_REPEAT_EN defined: REPEAT pulses at P+LONG_CNT+k*REPEAT_CNT, k>=1, while in LONGHELD; undefined: REPEAT tied to 0, LONGHELD only awaits release, REPEAT_CNT ignored.

Verification (STABLE_CNT=4, LONG_CNT=20, REPEAT_CNT=5)
REQ-025 RESET asserted mid-cycle with SIG_IN=1 -> all outputs 0 same cycle, no pulses until requalified.
REQ-026 SIG_IN high 3 cycles, then 0 -> LEVEL stays 0, no PRESS/RELEASE.
REQ-027 SIG_IN high 10 cycles from before edge 1 -> PRESS and LEVEL=1 at edge 6; RELEASE 6 cycles after fall; no LONG.
REQ-028 SIG_IN high 50 cycles -> LONG at P+20; with macro REPEAT at P+25, P+30, ...; without macro REPEAT never high.
REQ-029 Release timed so LEVEL falls at P+20 -> RELEASE at P+20, no LONG.
REQ-030 Bounce 1-0-1-0-1 per cycle then steady 1 -> exactly one PRESS, 6 cycles after final rise.
